dogx_startup_sequencer: RTL and testbench

Power-up and calibration controller for the DOGX converter, clocked from the 24 MHz DLL clock. On `enable` it runs a fixed, timer-driven sequence:
- enable the bandgap;
- start the DLL, then its feedback loop, and wait for lock;
- hold the converter reset, then release it;
- measure the static converter offset by averaging `converter_output` over 2^CAL_LOG2 samples.

It then reports `ready`. Its outputs gate the programmer's enable bits and drive the converter reset.

---
 rtl/dogx_seq_pkg.sv | 25 ++
 rtl/dogx_offset_averager.sv | 89 ++++++++
 rtl/dogx_startup_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_dogx_startup_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dogx_seq_pkg.sv
// Shared types and default timing for the DOGX startup sequencer.
package dogx_seq_pkg;

  localparam int CONV_W  = 11;
  localparam int TIMER_W = 16;

  localparam int T_BG_DEF         = 2400;
  localparam int T_DLL_EN_DEF     = 240;
  localparam int T_LOCK_MAX_DEF   = 4800;
  localparam int LOCK_FILT_DEF    = 16;
  localparam int T_CONV_RST_DEF   = 64;
  localparam int SKIP_SAMPLES_DEF = 4;
  localparam int CAL_LOG2_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BG_SETTLE = 3'd1,
    ST_DLL_START = 3'd2,
    ST_DLL_LOCK  = 3'd3,
    ST_CONV_RST  = 3'd4,
    ST_CAL       = 3'd5,
    ST_RUN       = 3'd6
  } state_e;

endpackage

// File: rtl/dogx_offset_averager.sv
// Averages converter samples after discarding the first few following reset release.
module dogx_offset_averager
  import dogx_seq_pkg::*;
#(
  parameter int SKIP_SAMPLES = SKIP_SAMPLES_DEF,
  parameter int CAL_LOG2     = CAL_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              active_i,
  input  logic              sample_valid_i,
  input  logic [CONV_W-1:0] data_i,
  output logic              done_o,
  output logic [CONV_W-1:0] result_o
);

  localparam int ACC_W  = CONV_W + CAL_LOG2;
  localparam int SKIP_W = $clog2(SKIP_SAMPLES + 2);
  localparam logic [SKIP_W-1:0]   SKIP_LIM = SKIP_W'(SKIP_SAMPLES);
  localparam logic [CAL_LOG2-1:0] CNT_LAST = {CAL_LOG2{1'b1}};

  logic [SKIP_W-1:0]       skip_q, skip_d;
  logic [CAL_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_s, shr_s;
  logic [CONV_W-1:0]       result_q, result_d;
  logic                    done_q, done_d;

  // Next-state for skip/sample counters, accumulator and the held result.
  always_comb begin
    skip_d   = skip_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = done_q;
    sum_s    = acc_q + {{CAL_LOG2{data_i[CONV_W-1]}}, data_i};
    shr_s    = sum_s >>> CAL_LOG2;
    if (start_i) begin
      // A new calibration invalidates the previous estimate's done flag,
      // but the estimate itself stays visible until replaced.
      skip_d = {SKIP_W{1'b0}};
      cnt_d  = {CAL_LOG2{1'b0}};
      acc_d  = {ACC_W{1'b0}};
      done_d = 1'b0;
    end else if (clear_i) begin
      skip_d = {SKIP_W{1'b0}};
      cnt_d  = {CAL_LOG2{1'b0}};
      acc_d  = {ACC_W{1'b0}};
    end else if (active_i && sample_valid_i && !done_q) begin
      if (skip_q != SKIP_LIM) begin
        skip_d = skip_q + SKIP_W'(1);
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CAL_LOG2'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = shr_s[CONV_W-1:0];
          done_d   = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
    end else begin
      done_d = done_q;
    end
  end

  // Averager state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skip_q   <= {SKIP_W{1'b0}};
      cnt_q    <= {CAL_LOG2{1'b0}};
      acc_q    <= {ACC_W{1'b0}};
      result_q <= {CONV_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      skip_q   <= skip_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: rtl/dogx_startup_sequencer.sv
// Timer-driven power-up and offset-calibration sequencer for the DOGX converter.
module dogx_startup_sequencer
  import dogx_seq_pkg::*;
#(
  parameter int T_BG         = T_BG_DEF,
  parameter int T_DLL_EN     = T_DLL_EN_DEF,
  parameter int T_LOCK_MAX   = T_LOCK_MAX_DEF,
  parameter int LOCK_FILT    = LOCK_FILT_DEF,
  parameter int T_CONV_RST   = T_CONV_RST_DEF,
  parameter int SKIP_SAMPLES = SKIP_SAMPLES_DEF,
  parameter int CAL_LOG2     = CAL_LOG2_DEF
) (
  input  logic              CLK_24M,
  input  logic              reset,
  input  logic              enable,
  input  logic              cal_bypass,
  input  logic              dll_lock,
  input  logic              sample_valid,
  input  logic [CONV_W-1:0] converter_output,
  output logic              bg_en,
  output logic              dll_en,
  output logic              dll_fb_en,
  output logic              conv_reset,
  output logic              cal_active,
  output logic [CONV_W-1:0] offset_est,
  output logic              cal_done,
  output logic              lock_timeout,
  output logic              ready,
  output logic [2:0]        state_o
);

  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [FILT_W-1:0]   filt_q, filt_d;
  logic                lock_timeout_q, lock_timeout_d;
  logic                bg_en_q, bg_en_d, dll_en_q, dll_en_d, dll_fb_en_q, dll_fb_en_d;
  logic                conv_reset_q, conv_reset_d, cal_active_q, cal_active_d;
  logic                ready_q, ready_d;
  logic                abort_s, timer_zero_s, lock_hit_s, entry_s;
  logic                cal_start_s, cal_done_s;

  // Dwell minus one, so a state loaded with T leaves after exactly T cycles.
  function automatic logic [TIMER_W-1:0] timer_load(input state_e st);
    case (st)
      ST_BG_SETTLE: return TIMER_W'(T_BG - 1);
      ST_DLL_START: return TIMER_W'(T_DLL_EN - 1);
      ST_DLL_LOCK:  return TIMER_W'(T_LOCK_MAX - 1);
      ST_CONV_RST:  return TIMER_W'(T_CONV_RST - 1);
      default:      return {TIMER_W{1'b0}};
    endcase
  endfunction

  // Next state, shared timer, lock filter and sticky timeout flag.
  always_comb begin
    state_d        = state_q;
    lock_timeout_d = lock_timeout_q;
    abort_s        = !enable && (state_q != ST_IDLE);
    timer_zero_s   = (timer_q == {TIMER_W{1'b0}});
    lock_hit_s     = (state_q == ST_DLL_LOCK) && dll_lock && (filt_q == FILT_LAST);
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = enable ? ST_BG_SETTLE : ST_IDLE;
        ST_BG_SETTLE: state_d = timer_zero_s ? ST_DLL_START : ST_BG_SETTLE;
        ST_DLL_START: state_d = timer_zero_s ? ST_DLL_LOCK : ST_DLL_START;
        ST_DLL_LOCK: begin
          // A lock seen on the last timeout cycle wins over the timeout.
          if (lock_hit_s) begin
            state_d = ST_CONV_RST;
          end else if (timer_zero_s) begin
            state_d        = ST_CONV_RST;
            lock_timeout_d = 1'b1;
          end else begin
            state_d = ST_DLL_LOCK;
          end
        end
        ST_CONV_RST: begin
          if (timer_zero_s) begin
            state_d = cal_bypass ? ST_RUN : ST_CAL;
          end else begin
            state_d = ST_CONV_RST;
          end
        end
        ST_CAL:  state_d = cal_done_s ? ST_RUN : ST_CAL;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    entry_s     = (state_d != state_q);
    cal_start_s = entry_s && (state_d == ST_CAL);

    if (entry_s) begin
      timer_d = timer_load(state_d);
    end else if (!timer_zero_s) begin
      timer_d = timer_q - TIMER_W'(1);
    end else begin
      timer_d = timer_q;
    end

    if (!abort_s && (state_q == ST_DLL_LOCK) && dll_lock) begin
      filt_d = filt_q + FILT_W'(1);
    end else begin
      filt_d = {FILT_W{1'b0}};
    end

    if (entry_s && (state_d == ST_BG_SETTLE)) begin
      lock_timeout_d = 1'b0;
    end else begin
      lock_timeout_d = lock_timeout_d;
    end
  end

  // Output decode from the next state so registered outputs track state_q.
  always_comb begin
    bg_en_d      = 1'b1;
    dll_en_d     = 1'b1;
    dll_fb_en_d  = 1'b1;
    conv_reset_d = 1'b0;
    cal_active_d = 1'b0;
    ready_d      = 1'b0;
    case (state_d)
      ST_IDLE: begin
        bg_en_d      = 1'b0;
        dll_en_d     = 1'b0;
        dll_fb_en_d  = 1'b0;
        conv_reset_d = 1'b1;
      end
      ST_BG_SETTLE: begin
        dll_en_d     = 1'b0;
        dll_fb_en_d  = 1'b0;
        conv_reset_d = 1'b1;
      end
      ST_DLL_START: begin
        dll_fb_en_d  = 1'b0;
        conv_reset_d = 1'b1;
      end
      ST_DLL_LOCK: conv_reset_d = 1'b1;
      ST_CONV_RST: conv_reset_d = 1'b1;
      ST_CAL:      cal_active_d = 1'b1;
      ST_RUN:      ready_d      = 1'b1;
      default: begin
        bg_en_d      = 1'b0;
        dll_en_d     = 1'b0;
        dll_fb_en_d  = 1'b0;
        conv_reset_d = 1'b1;
      end
    endcase
  end

  // State, timer, filter and registered outputs.
  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= {TIMER_W{1'b0}};
      filt_q         <= {FILT_W{1'b0}};
      lock_timeout_q <= 1'b0;
      bg_en_q        <= 1'b0;
      dll_en_q       <= 1'b0;
      dll_fb_en_q    <= 1'b0;
      conv_reset_q   <= 1'b1;
      cal_active_q   <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      filt_q         <= filt_d;
      lock_timeout_q <= lock_timeout_d;
      bg_en_q        <= bg_en_d;
      dll_en_q       <= dll_en_d;
      dll_fb_en_q    <= dll_fb_en_d;
      conv_reset_q   <= conv_reset_d;
      cal_active_q   <= cal_active_d;
      ready_q        <= ready_d;
    end
  end

  dogx_offset_averager #(
    .SKIP_SAMPLES(SKIP_SAMPLES),
    .CAL_LOG2    (CAL_LOG2)
  ) u_avg (
    .clk_i         (CLK_24M),
    .rst_ni        (reset),
    .start_i       (cal_start_s),
    .clear_i       (abort_s),
    .active_i      (state_q == ST_CAL),
    .sample_valid_i(sample_valid),
    .data_i        (converter_output),
    .done_o        (cal_done_s),
    .result_o      (offset_est)
  );

  assign bg_en        = bg_en_q;
  assign dll_en       = dll_en_q;
  assign dll_fb_en    = dll_fb_en_q;
  assign conv_reset   = conv_reset_q;
  assign cal_active   = cal_active_q;
  assign cal_done     = cal_done_s;
  assign lock_timeout = lock_timeout_q;
  assign ready        = ready_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dogx_startup_sequencer.sv
// Directed self-checking bench for the DOGX startup sequencer (short timing).
module tb_dogx_startup_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cal_bypass = 1'b0;
  logic        dll_lock = 1'b0;
  logic        sample_valid = 1'b0;
  logic [10:0] converter_output = 11'd0;
  logic        bg_en, dll_en, dll_fb_en, conv_reset, cal_active, cal_done, lock_timeout, ready;
  logic [10:0] offset_est;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;

  logic [10:0] samp_tab [0:15];
  int gen_idx = 0;
  int gen_phase = 0;

  dogx_startup_sequencer #(
    .T_BG(10), .T_DLL_EN(5), .T_LOCK_MAX(50), .LOCK_FILT(4),
    .T_CONV_RST(8), .SKIP_SAMPLES(2), .CAL_LOG2(3)
  ) dut (
    .CLK_24M(clk), .reset(rst_n), .enable(enable), .cal_bypass(cal_bypass),
    .dll_lock(dll_lock), .sample_valid(sample_valid), .converter_output(converter_output),
    .bg_en(bg_en), .dll_en(dll_en), .dll_fb_en(dll_fb_en), .conv_reset(conv_reset),
    .cal_active(cal_active), .offset_est(offset_est), .cal_done(cal_done),
    .lock_timeout(lock_timeout), .ready(ready), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Sample source: one pulse every 8 cycles while in CAL, restarting the table each CAL entry.
  always @(negedge clk) begin
    if (state_o == 3'd5) begin
      if (gen_phase == 7) begin
        sample_valid     <= 1'b1;
        converter_output <= samp_tab[gen_idx];
        if (gen_idx < 15) gen_idx <= gen_idx + 1;
      end else begin
        sample_valid <= 1'b0;
      end
      gen_phase <= (gen_phase + 1) % 8;
    end else begin
      sample_valid <= 1'b0;
      gen_idx      <= 0;
      gen_phase    <= 0;
    end
  end

  task automatic set_tab(input int skipv, input int first, input int rest);
    for (int i = 0; i < 16; i++) begin
      if (i < 2) samp_tab[i] = 11'(skipv);
      else if (i == 2) samp_tab[i] = 11'(first);
      else samp_tab[i] = 11'(rest);
    end
  endtask

  task automatic dwell(input logic [2:0] st, input int limit, output int n);
    n = 0;
    while (state_o == st && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_to_run();
    int budget = 0;
    while (state_o != 3'd6 && budget < 400) begin
      budget++;
      @(negedge clk);
    end
  endtask

  task automatic restart();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if ({bg_en, dll_en, dll_fb_en, cal_active, ready} !== 5'b00000) begin errors++; $display("FAIL reset_outs: got %b expected 00000", {bg_en, dll_en, dll_fb_en, cal_active, ready}); end
    checks++; if (conv_reset !== 1'b1) begin errors++; $display("FAIL reset_conv_reset: got %b expected 1", conv_reset); end
    checks++; if ({offset_est, cal_done, lock_timeout} !== 13'd0) begin errors++; $display("FAIL reset_cal: got %h expected 0", {offset_est, cal_done, lock_timeout}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state_o); end
  endtask

  task automatic test_bypass();
    int n;
    int exp_dw [4] = '{10, 5, 4, 8};
    cal_bypass = 1'b1;
    dll_lock   = 1'b1;
    enable     = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dwell(3'(i + 1), 100, n);
      checks++; if (n != exp_dw[i]) begin errors++; $display("FAIL bypass_dwell%0d: got %0d expected %0d", i + 1, n, exp_dw[i]); end
    end
    checks++; if (state_o !== 3'd6) begin errors++; $display("FAIL bypass_state: got %0d expected 6", state_o); end
    checks++; if (offset_est !== 11'd0 || cal_done !== 1'b0) begin errors++; $display("FAIL bypass_cal: got %0d/%b expected 0/0", offset_est, cal_done); end
    checks++; if (ready !== 1'b1 || conv_reset !== 1'b0) begin errors++; $display("FAIL bypass_ready: got %b/%b expected 1/0", ready, conv_reset); end
    cal_bypass = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    int exp_dw [5] = '{10, 5, 4, 8, 81};
    set_tab(-5, -5, -5);
    dll_lock = 1'b1;
    restart();
    checks++; if (state_o !== 3'd1 || bg_en !== 1'b1 || dll_en !== 1'b0 || conv_reset !== 1'b1) begin errors++; $display("FAIL nom_bg_outs: got st=%0d bg=%b dll=%b cr=%b expected 1/1/0/1", state_o, bg_en, dll_en, conv_reset); end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++; if (cal_active !== 1'b1 || conv_reset !== 1'b0) begin errors++; $display("FAIL nom_cal_outs: got %b/%b expected 1/0", cal_active, conv_reset); end
      end
      dwell(3'(i + 1), 200, n);
      checks++; if (n != exp_dw[i]) begin errors++; $display("FAIL nom_dwell%0d: got %0d expected %0d", i + 1, n, exp_dw[i]); end
      checks++; if (state_o !== 3'(i + 2)) begin errors++; $display("FAIL nom_next%0d: got %0d expected %0d", i + 1, state_o, i + 2); end
    end
    checks++; if (offset_est !== 11'h7FB) begin errors++; $display("FAIL nom_offset: got %0d expected -5", $signed(offset_est)); end
    checks++; if ({cal_done, ready, lock_timeout} !== 3'b110) begin errors++; $display("FAIL nom_flags: got %b expected 110", {cal_done, ready, lock_timeout}); end
    checks++; if ({bg_en, dll_en, dll_fb_en, conv_reset, cal_active} !== 5'b11100) begin errors++; $display("FAIL nom_run_outs: got %b expected 11100", {bg_en, dll_en, dll_fb_en, conv_reset, cal_active}); end
  endtask

  task automatic test_lock_timeout();
    int n;
    set_tab(7, 7, 7);
    dll_lock = 1'b0;
    restart();
    dwell(3'd1, 100, n);
    dwell(3'd2, 100, n);
    dwell(3'd3, 100, n);
    checks++; if (n != 50) begin errors++; $display("FAIL to_dwell: got %0d expected 50", n); end
    checks++; if (state_o !== 3'd4 || lock_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got st=%0d to=%b expected 4/1", state_o, lock_timeout); end
    run_to_run();
    checks++; if (ready !== 1'b1 || lock_timeout !== 1'b1 || offset_est !== 11'd7) begin errors++; $display("FAIL to_run: got rdy=%b to=%b off=%0d expected 1/1/7", ready, lock_timeout, offset_est); end
  endtask

  task automatic test_filter_reset();
    int n;
    logic [0:7] pat;
    pat = 8'b1110_1111;
    cal_bypass = 1'b1;
    dll_lock = 1'b0;
    restart();
    checks++; if (lock_timeout !== 1'b0) begin errors++; $display("FAIL filt_to_clear: got %b expected 0", lock_timeout); end
    dwell(3'd1, 100, n);
    dwell(3'd2, 100, n);
    n = 0;
    while (state_o == 3'd3 && n < 60) begin
      dll_lock = (n < 8) ? pat[n] : 1'b0;
      n++;
      @(negedge clk);
    end
    checks++; if (n != 8) begin errors++; $display("FAIL filt_dwell: got %0d expected 8", n); end
    checks++; if (state_o !== 3'd4 || lock_timeout !== 1'b0) begin errors++; $display("FAIL filt_exit: got st=%0d to=%b expected 4/0", state_o, lock_timeout); end
    dll_lock = 1'b1;
    run_to_run();
    checks++; if (offset_est !== 11'd7) begin errors++; $display("FAIL filt_offset_kept: got %0d expected 7", offset_est); end
    cal_bypass = 1'b0;
  endtask

  task automatic test_rounding();
    set_tab(500, -1, 0);
    dll_lock = 1'b1;
    restart();
    run_to_run();
    checks++; if (offset_est !== 11'h7FF || cal_done !== 1'b1) begin errors++; $display("FAIL round_neg: got %0d/%b expected -1/1", $signed(offset_est), cal_done); end
    set_tab(-1024, 1023, 1023);
    restart();
    run_to_run();
    checks++; if (offset_est !== 11'd1023) begin errors++; $display("FAIL round_max: got %0d expected 1023", $signed(offset_est)); end
  endtask

  task automatic test_abort_cal();
    int n;
    int budget;
    set_tab(100, 100, 100);
    dll_lock = 1'b1;
    restart();
    budget = 0;
    while (state_o != 3'd5 && budget < 200) begin budget++; @(negedge clk); end
    budget = 0;
    while (gen_idx != 5 && budget < 100) begin budget++; @(negedge clk); end
    checks++; if (gen_idx != 5) begin errors++; $display("FAIL abort_reach: got %0d expected 5", gen_idx); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== 3'd0 || conv_reset !== 1'b1 || bg_en !== 1'b0) begin errors++; $display("FAIL abort_idle: got st=%0d cr=%b bg=%b expected 0/1/0", state_o, conv_reset, bg_en); end
    checks++; if (offset_est !== 11'd1023 || cal_done !== 1'b0 || cal_active !== 1'b0) begin errors++; $display("FAIL abort_keep: got off=%0d cd=%b ca=%b expected 1023/0/0", offset_est, cal_done, cal_active); end
    set_tab(-9, 2, 2);
    enable = 1'b1;
    @(negedge clk);
    dwell(3'd1, 100, n);
    checks++; if (n != 10) begin errors++; $display("FAIL abort_rerun_bg: got %0d expected 10", n); end
    run_to_run();
    checks++; if (offset_est !== 11'd2 || cal_done !== 1'b1) begin errors++; $display("FAIL abort_rerun_avg: got %0d/%b expected 2/1", $signed(offset_est), cal_done); end
  endtask

  task automatic test_async_reset();
    restart();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 3'd0 || bg_en !== 1'b0 || conv_reset !== 1'b1) begin errors++; $display("FAIL async_state: got st=%0d bg=%b cr=%b expected 0/0/1", state_o, bg_en, conv_reset); end
    checks++; if (offset_est !== 11'd0 || cal_done !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL async_cal: got off=%0d cd=%b rdy=%b expected 0/0/0", offset_est, cal_done, ready); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_nominal();
    test_lock_timeout();
    test_filter_reset();
    test_rounding();
    test_abort_cal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
